// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop process one bit
// per clock, LSB first, behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] s_next;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  assign s_bit  = fa_sum(a_sh[0], b_sh[0], c);
  assign c_nxt  = fa_carry(a_sh[0], b_sh[0], c);
  // New bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign s_next = {s_bit, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_next;
          c    <= c_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= s_next;
            cout  <= c_nxt;
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);

endmodule
